robs_control: RTL
=================

# robs_control

- Moore-style sequencer for the signed Robertson's multiplier datapath (`robs_datapath`, WIDTH = 8).
- Accepts a start pulse and drives the 15-bit control word `c` through load, test/add, shift and count phases.
- Uses the datapath status flags `zr` (R even) and `zq` (count divisible by 8) for branching and termination.
- Raises `done` for one cycle when `product` = {A, X} is valid.

## Interface

- `WIDTH`, default 8: operand width. Fixed at 8, because `zq` termination means exactly 8 iterations.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low. Low forces the controller to IDLE immediately.
- `start` input 1: request a multiply. Sampled only in IDLE.
- `zr` input 1: from datapath. 1 = R LSB is 0, so the current multiplier bit is 0.
- `zq` input 1: from datapath. 1 = down-counter q ≡ 0 mod 8.
- `c` output 15: control word to the datapath, bit meanings below.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: high for exactly one cycle, in DONE.

## Operation

Control bit map. All bits are 0 unless listed for a state.
- c[0]: load Y.
- c[1]: clear q to 0.
- c[2]: clear A.
- c[3]: load X.
- c[5:4]: RH mux select. 0 = A, 1 = SR high, 2 = ALU.
- c[6]: RL mux select. 0 = X, 1 = SR low.
- c[7]: X mux select. 0 = multiplier, 1 = R low.
- c[8]: load RH.
- c[9]: load RL.
- c[10]: addsub mode. 1 = add, 0 = subtract.
- c[11]: arithmetic right shift SR by 1.
- c[12]: load SR from R.
- c[13]: decrement q.
- c[14]: load A.

States and per-state outputs:
- IDLE: c = 0. If `start` = 1, go to INIT.
- INIT: c[0], c[1], c[2], c[3] = 1, c[7] = 0. Internal 3-bit iteration index `it` is cleared to 0. Go to LOADR.
- LOADR: c[5:4] = 0, c[6] = 0, c[8], c[9] = 1, giving R = {0, multiplier}. Go to TEST.
- TEST: c = 0. If `zr` = 0, go to ADD; otherwise go to SHLD.
- ADD: c[10] = (it != 7). The last iteration subtracts Y, which is the sign-bit weight. addsub registers its result at the end of this cycle. Go to ADDWB.
- ADDWB: c[10] is held, c[5:4] = 2, c[8] = 1, so RH ← ALU result. Go to SHLD.
- SHLD: c[12] = 1. Go to SHIFT.
- SHIFT: c[11] = 1. Go to SHWB.
- SHWB: c[5:4] = 1, c[6] = 1, c[8], c[9] = 1, c[13] = 1. `it` increments, wrapping 7 → 0. Go to CHECK.
- CHECK: c = 0. If `zq` = 1, go to FINISH; otherwise go to TEST.
- FINISH: c[14] = 1, c[3] = 1, c[7] = 1, so A ← R high and X ← R low. Go to DONE.
- DONE: `done` = 1, c = 0. Go to IDLE.

Rules:
- `c`, `busy` and `done` are decoded only from the state register (plus `it` for c[10]). There is no combinational path from `start`, `zr` or `zq` to the outputs.
- `zq` is examined only in CHECK. q = 0 at the first TEST is not a termination condition.
- `start` outside IDLE is ignored and not queued.
- `start` held high through DONE is accepted in the following IDLE cycle, giving back-to-back operations.

## Timing

- Reset values: state = IDLE, `c` = 15'h0000, `busy` = 0, `done` = 0, `it` = 0.
- Reset is asynchronous. Outputs reach their reset values without waiting for a clock edge, including mid-operation. Datapath register contents are not restored.
- Iteration cost: TEST + SHLD + SHIFT + SHWB + CHECK = 5 cycles. Iterations with multiplier bit 1 add ADD + ADDWB, for 7 cycles.
- Latency: `start` is sampled high in IDLE at edge 0. `done` is high in cycle 44 + 2k, where k = popcount(multiplier). Minimum is 44 (k = 0), maximum is 60 (k = 8).
- `product` is valid from the DONE cycle and holds until the next INIT.
- q is 0 after INIT and is decremented once per iteration, so `zq` is first seen true in CHECK after 8 SHWB cycles (q = 248).

## Test plan

All scenarios run against `robs_datapath`.

- Reset: assert `reset` = 0 at an arbitrary time → `c` = 0, `busy` = 0, `done` = 0 with no clock edge. Release, then hold `start` = 0 for 10 cycles → still IDLE.
- Positive × positive: multiplier 8'h03, multiplicand 8'h05 → `done` at cycle 48, `product` = 16'h000F. ADD is visited exactly twice, both with c[10] = 1.
- Negative multiplier: multiplier 8'hFD (−3), multiplicand 8'h05 → `done` at cycle 58, `product` = 16'hFFF1. c[10] = 0 in exactly one ADD cycle (it = 7).
- Zero and extreme operands:
  - multiplier 8'h00, multiplicand 8'h7F → `done` at cycle 44, `product` = 0, ADD never visited.
  - multiplier 8'h80, multiplicand 8'h80 → `done` at cycle 46, `product` = 16'h4000.
- Handshake:
  - Pulse `start` during TEST → no effect, current result unchanged.
  - Hold `start` high through DONE → INIT follows IDLE within 2 cycles.
- Reset mid-run: drop `reset` during ADDWB of a 3 × 5 run → IDLE and `c` = 0 immediately. A new `start` with 8'hFB × 8'h06 (−5 × 6) → `product` = 16'hFFE2 with correct latency (k = 7 → cycle 58).

Source files
------------

// File: rtl/robs_control.sv
// Moore sequencer for the signed Robertson multiplier datapath.
// Outputs are registered from the next state, so they never depend on start, zr or zq.
module robs_control #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        zr,
    input  logic        zq,
    output logic [14:0] c,
    output logic        busy,
    output logic        done
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        LOADR,
        TEST,
        ADD,
        ADDWB,
        SHLD,
        SHIFT,
        SHWB,
        CHECK,
        FINISH,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   it_q, it_d;
    logic [14:0]     c_q;
    logic            busy_q;
    logic            done_q;

    // The sign-bit iteration subtracts Y instead of adding it.
    function automatic logic [14:0] cword(state_t s, logic [IW-1:0] it);
        logic [14:0] w;
        w = '0;
        case (s)
            INIT: w[3:0] = 4'hF;
            LOADR: begin
                w[8] = 1'b1;
                w[9] = 1'b1;
            end
            ADD: w[10] = (it != LAST);
            ADDWB: begin
                w[10]  = (it != LAST);
                w[5:4] = 2'd2;
                w[8]   = 1'b1;
            end
            SHLD:  w[12] = 1'b1;
            SHIFT: w[11] = 1'b1;
            SHWB: begin
                w[5:4] = 2'd1;
                w[6]   = 1'b1;
                w[8]   = 1'b1;
                w[9]   = 1'b1;
                w[13]  = 1'b1;
            end
            FINISH: begin
                w[14] = 1'b1;
                w[3]  = 1'b1;
                w[7]  = 1'b1;
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    always_comb begin
        state_d = state_q;
        it_d    = it_q;
        unique case (state_q)
            IDLE:   if (start) state_d = INIT;
            INIT: begin
                it_d    = '0;
                state_d = LOADR;
            end
            LOADR:  state_d = TEST;
            TEST:   state_d = zr ? SHLD : ADD;
            ADD:    state_d = ADDWB;
            ADDWB:  state_d = SHLD;
            SHLD:   state_d = SHIFT;
            SHIFT:  state_d = SHWB;
            SHWB: begin
                it_d    = it_q + 1'b1;
                state_d = CHECK;
            end
            CHECK:  state_d = zq ? FINISH : TEST;
            FINISH: state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            it_q    <= '0;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            it_q    <= it_d;
            c_q     <= cword(state_d, it_d);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign c    = c_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
